// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the round-robin arbitrated register mux: output-register
// state encodings, legal channel-count bounds and the pointer-width helper.
package rr_arb_mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    localparam int NUM_MIN = 2;
    localparam int NUM_MAX = 16;

    // Pointer must be at least one bit wide even for the two-channel case.
    function automatic int ptrWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational rotating-priority arbiter: the lowest requesting index at or
// above ptr (wrapping modulo NUM) receives a one-hot grant.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM = 4,
    localparam int PW = ptrWidth(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NUM-1:0] grant
);

    logic [2*NUM-1:0] w_reqDouble;
    logic [NUM-1:0]   w_reqRot;
    logic [NUM-1:0]   w_pickRot;
    logic [2*NUM-1:0] w_grantDouble;

    // Rotate requests so ptr lands on bit 0, isolate the lowest set bit, then
    // rotate the one-hot result back into channel order.
    assign w_reqDouble   = {req, req} >> ptr;
    assign w_reqRot      = w_reqDouble[NUM-1:0];
    assign w_pickRot     = w_reqRot & (-w_reqRot);
    assign w_grantDouble = {{NUM{1'b0}}, w_pickRot} << ptr;
    assign grant         = w_grantDouble[NUM-1:0] | w_grantDouble[2*NUM-1:NUM];

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated N:1 mux into a single output register with full
// throughput. Define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index priority.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM-1:0]       in_valid,
    input  logic [NUM*WIDTH-1:0] in_data,
    output logic [NUM-1:0]       in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [NUM-1:0]       out_sel
);

    localparam int PW = ptrWidth(NUM);

    arb_state_t       r_state;
    logic [WIDTH-1:0] r_data;
    logic [NUM-1:0]   r_sel;

    logic [NUM-1:0]   w_grant;
    logic [PW-1:0]    w_ptr;
    logic             w_load;
    logic             w_hs;
    logic [WIDTH-1:0] w_selData;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptrNext;

    // Next pointer is one past the granted channel, wrapping at NUM-1.
    always_comb begin
        w_ptrNext = '0;
        for (int i = 0; i < NUM; i++) begin
            if (w_grant[i]) begin
                w_ptrNext = (i == NUM - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= w_ptrNext;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_arbiter #(
        .NUM (NUM)
    ) u_arbiter (
        .req   (in_valid),
        .ptr   (w_ptr),
        .grant (w_grant)
    );

    // The register accepts a new beat when empty or draining this cycle.
    assign w_load   = (r_state == EMPTY) || out_ready;
    assign in_ready = (w_load && !rst) ? w_grant : '0;
    assign w_hs     = |in_ready;

    always_comb begin
        w_selData = '0;
        for (int i = 0; i < NUM; i++) begin
            w_selData = w_selData | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_hs) begin
                        r_state <= FULL;
                        r_data  <= w_selData;
                        r_sel   <= w_grant;
                    end
                end
                FULL: begin
                    if (w_hs) begin
                        r_data <= w_selData;
                        r_sel  <= w_grant;
                    end else if (out_ready) begin
                        r_state <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload bit width.
REQ-002 SHALL have parameter NUM, default 4: input channel count, legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, NUM bits: per-channel request.
REQ-006 SHALL have port in_data, input, NUM*WIDTH bits: channel i payload in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_ready, output, NUM bits: per-channel accept; at most one bit high.
REQ-008 SHALL have port out_valid, output, 1 bit: output register holds a payload.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-010 SHALL have port out_data, output, WIDTH bits: registered selected payload.
REQ-011 SHALL have port out_sel, output, NUM bits: registered one-hot source of out_data.

Function
REQ-012 SHALL form its grant from in_valid and a rotating priority pointer ptr; the lowest index at or above ptr (wrapping modulo NUM) with in_valid high wins.
REQ-013 SHALL define load = (!out_valid || out_ready); in_ready[i] = load && grant[i]; input handshake = in_valid[i] && in_ready[i].
REQ-014 SHALL register the granted payload on a handshake: out_data <= in_data[g], out_sel <= one-hot g, out_valid <= 1; latency exactly 1 cycle.
REQ-015 SHALL clear out_valid when out_valid && out_ready and no new handshake occurs in the same cycle.
REQ-016 SHALL support simultaneous output drain and input load in one cycle (full throughput, one beat per cycle).
REQ-017 SHALL hold out_data, out_sel, out_valid stable while out_valid && !out_ready (no grant change is visible on the output).
REQ-018 SHALL update ptr only on a handshake: ptr <= (g+1) mod NUM; wrap from NUM-1 to 0.
REQ-019 SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on handshake; FULL->EMPTY on drain without load; FULL->FULL on stall or drain+load.
REQ-020 SHALL drive in_ready all zero when no in_valid is high; ptr unchanged.
REQ-021 SHALL leave out_data unchanged when no handshake occurs.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, set out_valid=0, out_data=0, out_sel=0, ptr=0, regardless of in_valid/out_ready.
REQ-023 SHALL drive in_ready all zero during any cycle rst=1; a payload held at reset is discarded.

Configuration
REQ-024 SHALL, when macro RR_ARB_MUX_FIXED_PRIO_EN is defined, use fixed priority (lowest index wins) with ptr held at 0 permanently and no pointer register inferred.
REQ-025 SHALL, when RR_ARB_MUX_FIXED_PRIO_EN is undefined, use round-robin per REQ-012 and REQ-018.

Structure
REQ-026 SHALL place the state encodings (EMPTY=0, FULL=1) and the NUM legal-range bounds in the shared constants package/header of the npc vsrc tree.
REQ-027 SHALL split off one combinational sub-module, rr_arbiter (params NUM; inputs req, ptr; output one-hot grant); rr_arb_mux instantiates it once.
REQ-028 SHALL compute the payload selection as an AND-OR of one-hot grant against each channel, sized by WIDTH.

Verification
REQ-029 Reset: rst=1 with in_valid=4'b1111, out_ready=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-030 Round-robin: NUM=4, in_valid=4'b1111 held, in_data=ch i = 0xA0+i, out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles after 1-cycle latency.
REQ-031 Back-pressure: out_valid=1 with 0xA1, out_ready=0 for 3 cycles, in_valid=4'b0100 -> in_ready=0, out_data stays 0xA1, out_sel=4'b0010; on out_ready=1 -> in_ready=4'b0100 that cycle, next out_data=0xA2.
REQ-032 Wrap/skip: ptr=3, in_valid=4'b0011 -> grant channel 0, then ptr=1; next grant channel 1.
REQ-033 Drain-only: out_valid=1, out_ready=1, in_valid=0 -> next cycle out_valid=0, out_data unchanged.
REQ-034 Macro build with RR_ARB_MUX_FIXED_PRIO_EN: in_valid=4'b1010 held, out_ready=1 -> every output beat from channel 1, out_sel=4'b0010.
